// File: rtl/adder_seq_ctrl_pkg.sv
// Shared types and constants for the multi-cycle wide-adder sequencer.
package adder_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEF_WIDTH = 512;
  localparam int DEF_CHUNK = 64;

  // Width of a counter able to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Request/result handshake bundle between producers, the sequencer and consumers.
interface adder_seq_ctrl_if #(
  parameter int WIDTH = 512
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_carry, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_carry, out_ready,
    output in_ready, out_valid, out_sum, busy
  );
endinterface

// File: rtl/adder_seq_ctrl_slice.sv
// Combinational CHUNK-bit slice adder with carry in and carry out.
module adder_slice #(
  parameter int CHUNK = 64
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, carry_in};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide adder sequencer: latches operands, ripples one shared slice adder over
// BEATS cycles with a registered carry, then holds the result for the consumer.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clock,
  input  logic             reset,
  adder_seq_ctrl_if.slave  bus
);

  localparam int BEATS  = WIDTH / CHUNK;
  localparam int BEAT_W = clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t state_reg;
  state_t state_next;

  logic [BEAT_W-1:0] beat_reg;
  logic              carry_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  result_reg;

  logic [CHUNK-1:0]  slice_a;
  logic [CHUNK-1:0]  slice_b;
  logic [CHUNK-1:0]  slice_sum;
  logic              slice_carry;
  logic              accept;
  logic              last_beat;

  assign accept    = bus.in_valid && (state_reg == IDLE);
  assign last_beat = (beat_reg == LAST_BEAT);
  assign slice_a   = a_reg[beat_reg*CHUNK +: CHUNK];
  assign slice_b   = b_reg[beat_reg*CHUNK +: CHUNK];

  adder_slice #(.CHUNK(CHUNK)) u_slice (
    .a         (slice_a),
    .b         (slice_b),
    .carry_in  (carry_reg),
    .sum       (slice_sum),
    .carry_out (slice_carry)
  );

  always_ff @(posedge clock) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_beat) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      beat_reg   <= '0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else if (accept) begin
      a_reg     <= bus.in_a;
      b_reg     <= bus.in_b;
      carry_reg <= bus.in_carry;
      beat_reg  <= '0;
    end else if (state_reg == RUN) begin
      result_reg[beat_reg*CHUNK +: CHUNK] <= slice_sum;
      carry_reg <= slice_carry;
      beat_reg  <= last_beat ? '0 : beat_reg + 1'b1;
    end
  end

  // Outputs are gated by reset so nothing is advertised while it is held low.
  assign bus.in_ready  = reset && (state_reg == IDLE);
  assign bus.out_valid = reset && (state_reg == DONE);
  assign bus.busy      = reset && (state_reg != IDLE);
  assign bus.out_sum   = bus.out_valid ? {carry_reg, result_reg} : '0;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Randomized self-checking bench for adder_seq_ctrl against an arithmetic reference.
module tb_adder_seq_ctrl;

  localparam int W     = 512;
  localparam int C     = 64;
  localparam int BEATS = W / C;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   cyc_cnt;
  int   acc_cyc;

  adder_seq_ctrl_if #(.WIDTH(W)) bus ();

  adder_seq_ctrl #(.WIDTH(W), .CHUNK(C)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Presents a request and returns just after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_carry = c;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("accept_timeout", (n < 100), 1);
    @(posedge clock);
    #1;
    acc_cyc = cyc_cnt;
  endtask

  // Waits for the result, checks latency/value/stability, then completes the handshake.
  task automatic finish_op(input logic [W:0] exp, input int hold, input bit noise,
                           input string tag);
    int lat;
    @(negedge clock);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (noise) begin
        bus.in_valid  = $urandom_range(0, 1);
        bus.in_a      = rand_wide();
        bus.out_ready = $urandom_range(0, 1);
      end
      check({tag, "_run_ready"}, bus.in_ready, 0);
      @(negedge clock);
      lat++;
    end
    check({tag, "_latency"}, lat, BEATS);
    check({tag, "_sum"}, bus.out_sum, exp);
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        bus.in_valid = 1'b1;
        bus.in_a     = 3;
      end
      @(negedge clock);
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_sum"}, bus.out_sum, exp);
      check({tag, "_hold_ready"}, bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    check({tag, "_release"}, bus.out_valid, 0);
    check({tag, "_sum_zero"}, bus.out_sum, 0);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int hold, input bit noise, input string tag);
    logic [W:0] exp;
    exp = ref_add(a, b, c);
    send(a, b, c);
    bus.in_valid = 1'b0;
    finish_op(exp, hold, noise, tag);
  endtask

  logic [W-1:0] ones;
  logic [W-1:0] p100;
  logic [W-1:0] p511;
  logic [W:0]   carry_only;
  logic [W:0]   exp2;
  int           t1;
  int           n;
  bit           seen;

  initial begin
    checks        = 0;
    errors        = 0;
    cyc_cnt       = 0;
    ones          = '1;
    p100          = '0;
    p100[100]     = 1'b1;
    p511          = '0;
    p511[511]     = 1'b1;
    carry_only    = '0;
    carry_only[W] = 1'b1;
    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = rand_wide();
    bus.in_b      = rand_wide();
    bus.in_carry  = 1'b1;
    bus.out_ready = 1'b0;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_sum", bus.out_sum, 0);
      check("rst_busy", bus.busy, 0);
    end
    reset = 1'b1;
    #1;
    check("rst_release_ready", bus.in_ready, 1);
    bus.in_valid = 1'b0;

    run_op(5, 7, 1'b1, 0, 0, "basic");
    run_op(ones, 1, 1'b0, 0, 0, "ripple_b1");
    run_op(ones, 0, 1'b1, 0, 0, "ripple_cin");
    check("ripple_ref", ref_add(ones, 0, 1'b1), carry_only);
    run_op(rand_wide(), rand_wide(), 1'b1, 10, 1, "backpressure");

    // Abort at beat 4; no result may appear afterwards
    send(rand_wide(), rand_wide(), 1'b1);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clock);
    check("abort_busy", bus.busy, 1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (bus.out_valid) seen = 1;
    end
    check("abort_no_valid", seen, 0);
    bus.out_ready = 1'b0;
    run_op(p100, p100, 1'b0, 0, 0, "post_abort");

    // Back-to-back with the consumer always ready
    bus.out_ready = 1'b1;
    exp2 = ref_add(p511, p511, 1'b0);
    send(1, 1, 1'b0);
    t1 = acc_cyc;
    bus.in_a     = p511;
    bus.in_b     = p511;
    bus.in_carry = 1'b0;
    seen = 0;
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (bus.out_valid) begin
        seen = 1;
        check("b2b_first_sum", bus.out_sum, 2);
      end
      if (bus.in_ready) break;
    end
    check("b2b_first_seen", seen, 1);
    @(posedge clock);
    #1;
    check("b2b_period", acc_cyc == 0 ? 0 : cyc_cnt - t1, BEATS + 2);
    bus.in_valid = 1'b0;
    finish_op(exp2, 0, 0, "b2b_second");
    check("b2b_second_ref", exp2, carry_only);

    for (int k = 0; k < 16; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = ($urandom_range(0, 3) == 0) ? ones : rand_wide();
      rb = ($urandom_range(0, 3) == 0) ? W'(1) : rand_wide();
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1,
             $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
